fpu_realt_aligner: RTL and testbench
====================================

Name: fpu_realt_aligner

Overview:
Pairing stage upstream of the real_t result checker. It buffers expected results from the behavioural FPU model in a FIFO until the RTL FPU pipeline emits the matching result. It then presents each expected/actual pair together, registered and time-aligned, on the checker's i_rez_sim / i_rez_rtl inputs. It also flags alignment faults (underflow, overflow) and counts the pairs it delivers.

Parameters:
N_REZ, 3, number of real_t lanes per result word (same meaning as in the checker)
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of pair counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
i_sim_vld  input  1  expected-result word valid
i_rez_sim  input  real_t[N_REZ]  expected result from behavioural model
i_rtl_vld  input  1  RTL result word valid
i_rez_rtl  input  real_t[N_REZ]  RTL pipeline result
o_vld  output  1  aligned pair valid (one-cycle pulse per pair)
o_rez_sim  output  real_t[N_REZ]  aligned expected result; feeds checker i_rez_sim
o_rez_rtl  output  real_t[N_REZ]  aligned RTL result; feeds checker i_rez_rtl
o_level  output  $clog2(DEPTH)+1  current FIFO occupancy
o_unf  output  1  sticky: RTL result arrived with no expected entry available
o_ovf  output  1  sticky: expected result dropped because FIFO full
o_pairs  output  CNT_W  number of pairs delivered, saturating

Behaviour:
- Reset (synchronous, active-high, dominates all other events):
  - FIFO pointers and o_level cleared to 0.
  - o_vld, o_unf, o_ovf cleared to 0; o_pairs cleared to 0.
  - o_rez_sim and o_rez_rtl cleared to all-zero (sign=0, expn=0, frac=0) in every lane.
  - Reset mid-operation discards all buffered entries; no pair is emitted for the reset cycle.
- FIFO: circular buffer of DEPTH entries, each N_REZ real_t. Write/read pointers carry one extra wrap bit.
  - full when level == DEPTH; empty when level == 0.
- Push: i_sim_vld and (not full, or a pop occurs in the same cycle). Entry written at the write pointer; pointer increments with wrap.
- Pop: i_rtl_vld and not empty. Entry read at the read pointer; pointer increments with wrap.
- Level update: push only +1; pop only -1; push and pop together leaves level unchanged.
- Bypass: if empty and both i_sim_vld and i_rtl_vld are high, i_rez_sim pairs directly with i_rez_rtl.
  - Nothing is written; level stays 0; no underflow.
- Output register, latency 1 cycle from accepted i_rtl_vld:
  - o_vld=1 and o_rez_rtl = registered i_rez_rtl.
  - o_rez_sim = popped entry, or the bypassed i_rez_sim.
- On cycles with no pair, o_vld=0 and o_rez_sim / o_rez_rtl hold their last values. This keeps the downstream checker, which compares every clock, from seeing spurious deltas.
- Underflow: i_rtl_vld while empty and no bypass.
  - No pair emitted (o_vld=0); o_rez_* hold; o_unf set and held until rst.
- Overflow: i_sim_vld while full and no pop in the same cycle.
  - Input word dropped; FIFO contents unchanged; o_ovf set and held until rst.
- o_pairs increments by 1 on each cycle o_vld is registered high; saturates at 2^CNT_W-1, no wrap.
- Fields are copied bit-exact. No arithmetic is applied to sign, expn or frac.
- Ordering: strict FIFO. The k-th accepted expected word pairs with the k-th accepted RTL word.

Test Plan:
- Fixed latency 5: push sim words A0..A9 one per cycle; RTL words R0..R9 follow 5 cycles later.
  - Expect o_vld 1 cycle after each R.
  - Expect o_rez_sim=Ak paired with o_rez_rtl=Rk in order.
  - Expect o_level peaks at 5; o_pairs=10; o_unf=o_ovf=0.
- Fill/wrap: push DEPTH=16 words (lane0 frac=0..15) with no RTL, then one extra push.
  - Expect o_level=16 and o_ovf=1.
  - Then drain 16 RTL valids: sim frac sequence 0..15 exactly; o_level=0.
  - Repeat 3 times without reset to exercise pointer wrap.
- Full with simultaneous push+pop: at level 16, assert i_sim_vld and i_rtl_vld together.
  - Expect no overflow; level stays 16.
  - Expect the new word emerges 16 pops later.
- Bypass: empty FIFO, both valids in the same cycle with sim expn=8'h7F, rtl expn=8'h7F.
  - Next cycle: o_vld=1, both outputs carry expn 7F; o_level stays 0.
- Underflow: empty FIFO, i_rtl_vld alone.
  - Expect o_unf=1; o_vld=0; outputs unchanged; the next normal pair still aligns.
- Reset mid-operation: level=7; assert rst for 1 cycle.
  - Next cycle: o_level=0; o_vld/o_unf/o_ovf=0; o_pairs=0; outputs all-zero.
  - A subsequent RTL valid sets o_unf.

Source files
------------

// File: rtl/fpu_realt_aligner_if.sv
// real_t payload type and the aligner bus interface.
// The producer/consumer side (bench or surrounding checker) uses master; the aligner uses slave.

package fpu_realt_aligner_pkg;

  localparam int unsigned EXPN_W = 8;
  localparam int unsigned FRAC_W = 23;

  typedef struct packed {
    logic              sign;
    logic [EXPN_W-1:0] expn;
    logic [FRAC_W-1:0] frac;
  } real_t;

endpackage

interface fpu_realt_aligner_if #(
  parameter int unsigned N_REZ = 3,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  // Inputs to the aligner
  logic                                     i_sim_vld;
  fpu_realt_aligner_pkg::real_t [N_REZ-1:0] i_rez_sim;
  logic                                     i_rtl_vld;
  fpu_realt_aligner_pkg::real_t [N_REZ-1:0] i_rez_rtl;

  // Outputs from the aligner
  logic                                     o_vld;
  fpu_realt_aligner_pkg::real_t [N_REZ-1:0] o_rez_sim;
  fpu_realt_aligner_pkg::real_t [N_REZ-1:0] o_rez_rtl;
  logic [LVL_W-1:0]                         o_level;
  logic                                     o_unf;
  logic                                     o_ovf;
  logic [CNT_W-1:0]                         o_pairs;

  modport master (
    output i_sim_vld, i_rez_sim, i_rtl_vld, i_rez_rtl,
    input  o_vld, o_rez_sim, o_rez_rtl, o_level, o_unf, o_ovf, o_pairs
  );

  modport slave (
    input  i_sim_vld, i_rez_sim, i_rtl_vld, i_rez_rtl,
    output o_vld, o_rez_sim, o_rez_rtl, o_level, o_unf, o_ovf, o_pairs
  );

endinterface

// File: rtl/fpu_realt_aligner.sv
// Pairs expected results (behavioural model) with RTL FPU results in strict
// arrival order and presents each pair registered on the checker inputs.
// Expected words wait in a circular FIFO until the matching RTL word shows up.

module fpu_realt_aligner #(
  parameter int unsigned N_REZ = 3,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_realt_aligner_if.slave   bus
);

  import fpu_realt_aligner_pkg::*;

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned LVL_W = AW + 1;

  typedef real_t [N_REZ-1:0] word_t;

  // Storage and pointers (pointers carry a wrap bit above the index)
  word_t            r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;

  // Registered outputs
  logic             r_vld;
  word_t            r_rez_sim;
  word_t            r_rez_rtl;
  logic             r_unf;
  logic             r_ovf;
  logic [CNT_W-1:0] r_pairs;

  // Per-cycle decisions
  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_pop;
  logic             w_push;
  logic             w_pair;
  logic             w_unf;
  logic             w_ovf;
  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  word_t            w_rd_word;
  word_t            w_pair_sim;

  // Status from pointer comparison; equal index with differing wrap bit means full
  always_comb begin
    w_widx  = r_wptr[AW-1:0];
    w_ridx  = r_rptr[AW-1:0];
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  end

  // Accept/pop/pair decisions; an empty FIFO with both valids pairs straight through
  always_comb begin
    w_bypass   = w_empty && bus.i_sim_vld && bus.i_rtl_vld;
    w_pop      = bus.i_rtl_vld && !w_empty;
    w_push     = bus.i_sim_vld && !w_bypass && (!w_full || w_pop);
    w_pair     = w_pop || w_bypass;
    w_unf      = bus.i_rtl_vld && w_empty && !bus.i_sim_vld;
    w_ovf      = bus.i_sim_vld && w_full && !w_pop;
    w_rd_word  = r_mem[w_ridx];
    w_pair_sim = w_bypass ? bus.i_rez_sim : w_rd_word;
  end

  // FIFO storage write; contents need no reset since pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_widx] <= bus.i_rez_sim;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // Output pair register; data holds between pairs so the checker sees no spurious deltas
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= 1'b0;
      r_rez_sim <= '0;
      r_rez_rtl <= '0;
    end else begin
      r_vld <= w_pair;
      if (w_pair) begin
        r_rez_sim <= w_pair_sim;
        r_rez_rtl <= bus.i_rez_rtl;
      end
    end
  end

  // Sticky fault flags and saturating pair counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_unf   <= 1'b0;
      r_ovf   <= 1'b0;
      r_pairs <= '0;
    end else begin
      r_unf <= r_unf || w_unf;
      r_ovf <= r_ovf || w_ovf;
      if (w_pair && (r_pairs != {CNT_W{1'b1}})) begin
        r_pairs <= r_pairs + CNT_W'(1);
      end
    end
  end

  assign bus.o_vld     = r_vld;
  assign bus.o_rez_sim = r_rez_sim;
  assign bus.o_rez_rtl = r_rez_rtl;
  assign bus.o_level   = r_level;
  assign bus.o_unf     = r_unf;
  assign bus.o_ovf     = r_ovf;
  assign bus.o_pairs   = r_pairs;

endmodule

// File: tb/tb_fpu_realt_aligner.sv
// Scoreboard bench for fpu_realt_aligner: a queue-based reference model
// predicts pairs and status; a monitor checks the DUT one cycle later.

module tb_fpu_realt_aligner;

  import fpu_realt_aligner_pkg::*;

  localparam int unsigned N_REZ = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 32;

  typedef real_t [N_REZ-1:0] rvec_t;

  typedef struct {
    logic             vld;
    int unsigned      level;
    logic             unf;
    logic             ovf;
    logic [CNT_W-1:0] pairs;
    rvec_t            sim;
    rvec_t            rtl;
  } stat_t;

  typedef struct {
    rvec_t sim;
    rvec_t rtl;
  } pair_t;

  logic clk = 1'b0;
  logic rst;

  fpu_realt_aligner_if #(.N_REZ(N_REZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_if ();

  fpu_realt_aligner #(.N_REZ(N_REZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state
  rvec_t            mq[$];
  logic             m_unf;
  logic             m_ovf;
  logic [CNT_W-1:0] m_pairs;
  rvec_t            m_sim;
  rvec_t            m_rtl;
  stat_t            stat_q[$];
  pair_t            pair_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rvec_t rnd();
    rvec_t v;
    for (int i = 0; i < N_REZ; i++) v[i] = real_t'($urandom);
    return v;
  endfunction

  // Drive one cycle of inputs and predict the resulting DUT state
  task automatic drive(input logic r, input logic sv, input rvec_t s,
                       input logic rv, input rvec_t rt);
    stat_t st;
    logic  vld;
    rvec_t a;
    logic  emit;
    @(negedge clk);
    rst              = r;
    bus_if.i_sim_vld = sv;
    bus_if.i_rez_sim = s;
    bus_if.i_rtl_vld = rv;
    bus_if.i_rez_rtl = rt;
    emit = 1'b0;
    a    = '0;
    if (r) begin
      mq.delete();
      m_unf   = 1'b0;
      m_ovf   = 1'b0;
      m_pairs = '0;
      m_sim   = '0;
      m_rtl   = '0;
    end else if (rv && mq.size() > 0) begin
      a    = mq.pop_front();
      emit = 1'b1;
      if (sv) mq.push_back(s);
    end else if (rv && sv) begin
      a    = s;
      emit = 1'b1;
    end else if (rv) begin
      m_unf = 1'b1;
    end else if (sv) begin
      if (mq.size() < DEPTH) mq.push_back(s);
      else m_ovf = 1'b1;
    end
    vld = emit;
    if (emit) begin
      m_sim = a;
      m_rtl = rt;
      if (m_pairs != {CNT_W{1'b1}}) m_pairs = m_pairs + 1;
      pair_q.push_back('{sim: a, rtl: rt});
    end
    st.vld   = vld;
    st.level = mq.size();
    st.unf   = m_unf;
    st.ovf   = m_ovf;
    st.pairs = m_pairs;
    st.sim   = m_sim;
    st.rtl   = m_rtl;
    stat_q.push_back(st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: compare status every predicted cycle; pop a pair whenever the DUT presents one
  initial begin
    stat_t st;
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() > 0) begin
        st = stat_q.pop_front();
        chk("o_vld",   128'(bus_if.o_vld),   128'(st.vld));
        chk("o_level", 128'(bus_if.o_level), 128'(st.level));
        chk("o_unf",   128'(bus_if.o_unf),   128'(st.unf));
        chk("o_ovf",   128'(bus_if.o_ovf),   128'(st.ovf));
        chk("o_pairs", 128'(bus_if.o_pairs), 128'(st.pairs));
        if (bus_if.o_vld === 1'b1) begin
          if (pair_q.size() == 0) begin
            chk("unexpected_pair", 128'(1), 128'(0));
          end else begin
            p = pair_q.pop_front();
            chk("pair_sim", 128'(bus_if.o_rez_sim), 128'(p.sim));
            chk("pair_rtl", 128'(bus_if.o_rez_rtl), 128'(p.rtl));
          end
        end else begin
          chk("hold_sim", 128'(bus_if.o_rez_sim), 128'(st.sim));
          chk("hold_rtl", 128'(bus_if.o_rez_rtl), 128'(st.rtl));
        end
      end
    end
  end

  initial begin
    rvec_t a[10];
    rvec_t rr[10];
    rvec_t w;
    rvec_t w2;
    rvec_t s;
    rvec_t t;
    logic  sv;
    logic  rv;
    rst              = 1'b1;
    bus_if.i_sim_vld = 1'b0;
    bus_if.i_rez_sim = '0;
    bus_if.i_rtl_vld = 1'b0;
    bus_if.i_rez_rtl = '0;

    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(2);

    // Fixed latency 5 between expected and RTL streams
    for (int k = 0; k < 10; k++) begin
      a[k]  = rnd();
      rr[k] = rnd();
    end
    for (int k = 0; k < 15; k++) begin
      sv = (k < 10);
      rv = (k >= 5);
      s  = sv ? a[k % 10] : '0;
      t  = rv ? rr[(k + 5) % 10] : '0;
      drive(1'b0, sv, s, rv, t);
    end
    idle(2);

    // Fill to full, overflow once, drain; three rounds to wrap the pointers
    for (int rep = 0; rep < 3; rep++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w = rnd();
        w[0].frac = 23'(j);
        drive(1'b0, 1'b1, w, 1'b0, '0);
      end
      drive(1'b0, 1'b1, rnd(), 1'b0, '0);
      for (int j = 0; j < DEPTH; j++) drive(1'b0, 1'b0, '0, 1'b1, rnd());
      idle(1);
    end

    // Full with simultaneous push and pop; new word emerges after 16 pops
    for (int j = 0; j < DEPTH; j++) drive(1'b0, 1'b1, rnd(), 1'b0, '0);
    w2 = rnd();
    drive(1'b0, 1'b1, w2, 1'b1, rnd());
    for (int j = 0; j < DEPTH; j++) drive(1'b0, 1'b0, '0, 1'b1, rnd());
    idle(1);

    // Bypass on empty FIFO
    s = rnd();
    t = rnd();
    s[0].expn = 8'h7F;
    t[0].expn = 8'h7F;
    drive(1'b0, 1'b1, s, 1'b1, t);
    idle(1);

    // Underflow then a normal pair
    drive(1'b0, 1'b0, '0, 1'b1, rnd());
    idle(1);
    drive(1'b0, 1'b1, rnd(), 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, rnd());
    idle(1);

    // Reset mid-operation at level 7
    for (int j = 0; j < 7; j++) drive(1'b0, 1'b1, rnd(), 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    drive(1'b0, 1'b0, '0, 1'b1, rnd());
    idle(1);
    drive(1'b1, 1'b0, '0, 1'b0, '0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      sv = ($urandom_range(99) < 55);
      rv = ($urandom_range(99) < 50);
      drive(($urandom_range(299) == 0), sv, rnd(), rv, rnd());
    end
    idle(3);

    for (int i = 0; i < 20 && stat_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("monitor_drained", 128'(stat_q.size()), 128'(0));
    chk("pairs_drained",   128'(pair_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
